// File: rtl/coin_pkg.sv
// Coin acceptor shared definitions.
//   state_e   : controller states
//   COIN_*    : {sense_1, sense_2} sensor patterns used as coin identifiers
package coin_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB,
    HELD,
    REJECT,
    JAM
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b10;
  localparam logic [1:0] COIN_2    = 2'b01;
  localparam logic [1:0] COIN_BOTH = 2'b11;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for one asynchronous level input.
//   clk, rst_n : clock, asynchronous active-low reset (flops reset to 0)
//   i_en       : advance enable; low holds both flops
//   i_d        : raw asynchronous input
//   o_q        : synchronised output
module bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else if (i_en) begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises and debounces the two optical coin sensors,
// issues one strobe per validated coin, drives the reject flap, flags sensor jams and
// keeps saturating per-denomination audit counters.
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_ena           : global enable; low freezes all state, strobes forced low
//   i_sense_1/2     : raw asynchronous sensors (1-rupee / 2-rupee), high = coin present
//   i_accept_en     : accept coins when high, divert to reject when low
//   i_clr_counts    : synchronous clear of both counters (wins over an increment)
//   o_coin_1/2      : single-cycle accepted-coin strobes
//   o_reject_gate   : reject flap open
//   o_jam           : sensor jam flag
//   o_count_1/2     : saturating accepted-coin counters
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned JAM_CYCLES      = 1024,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ena,
  input  logic             i_sense_1,
  input  logic             i_sense_2,
  input  logic             i_accept_en,
  input  logic             i_clr_counts,
  output logic             o_coin_1,
  output logic             o_coin_2,
  output logic             o_reject_gate,
  output logic             o_jam,
  output logic [CNT_W-1:0] o_count_1,
  output logic [CNT_W-1:0] o_count_2
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned JW = (JAM_CYCLES > 2) ? $clog2(JAM_CYCLES) : 1;

  logic             w_s1;
  logic             w_s2;
  logic [1:0]       w_sense;
  logic             w_stable;
  logic             w_deb_done;
  logic             w_decide;
  logic             w_take_1;
  logic             w_take_2;

  state_e           r_state;
  logic [1:0]       r_cap;
  logic [DW-1:0]    r_deb;
  logic [JW-1:0]    r_jamc;
  logic             r_coin_1;
  logic             r_coin_2;
  logic             r_reject;
  logic             r_jam;
  logic [CNT_W-1:0] r_cnt_1;
  logic [CNT_W-1:0] r_cnt_2;

  bit_sync u_sync_1 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (i_ena),
    .i_d   (i_sense_1),
    .o_q   (w_s1)
  );

  bit_sync u_sync_2 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (i_ena),
    .i_d   (i_sense_2),
    .o_q   (w_s2)
  );

  assign w_sense = {w_s1, w_s2};

  // r_cap holds the pattern captured on state entry; after the DEB decision it is
  // COIN_NONE, so the same timer then measures the stable-low release time.
  assign w_stable   = (w_sense == r_cap);
  assign w_deb_done = (r_deb == DW'(DEBOUNCE_CYCLES - 1));
  assign w_decide   = (r_state == DEB) && w_stable && w_deb_done;
  assign w_take_1   = w_decide && i_accept_en && (r_cap == COIN_1);
  assign w_take_2   = w_decide && i_accept_en && (r_cap == COIN_2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cap    <= COIN_NONE;
      r_deb    <= '0;
      r_jamc   <= '0;
      r_coin_1 <= 1'b0;
      r_coin_2 <= 1'b0;
      r_reject <= 1'b0;
      r_jam    <= 1'b0;
    end else if (i_ena) begin
      r_coin_1 <= w_take_1;
      r_coin_2 <= w_take_2;
      unique case (r_state)
        IDLE: begin
          if (w_sense != COIN_NONE) begin
            r_state <= DEB;
            r_cap   <= w_sense;
            r_deb   <= '0;
          end
        end
        DEB: begin
          if (!w_stable) begin
            r_state <= IDLE;
          end else if (w_deb_done) begin
            r_cap  <= COIN_NONE;
            r_deb  <= '0;
            r_jamc <= '0;
            if (w_take_1 || w_take_2) begin
              r_state <= HELD;
            end else begin
              r_state  <= REJECT;
              r_reject <= 1'b1;
            end
          end else begin
            r_deb <= r_deb + DW'(1);
          end
        end
        HELD, REJECT: begin
          if (w_stable) begin
            if (w_deb_done) begin
              r_state  <= IDLE;
              r_reject <= 1'b0;
            end else begin
              r_deb <= r_deb + DW'(1);
            end
          end else begin
            // Jam time accumulates over every coin-present cycle, not just a single run.
            r_deb <= '0;
            if (r_jamc == JW'(JAM_CYCLES - 1)) begin
              r_state  <= JAM;
              r_jam    <= 1'b1;
              r_reject <= 1'b1;
            end else begin
              r_jamc <= r_jamc + JW'(1);
            end
          end
        end
        JAM: begin
          if (w_stable) begin
            if (w_deb_done) begin
              r_state  <= IDLE;
              r_jam    <= 1'b0;
              r_reject <= 1'b0;
            end else begin
              r_deb <= r_deb + DW'(1);
            end
          end else begin
            r_deb <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end else begin
      r_coin_1 <= 1'b0;
      r_coin_2 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_1 <= '0;
      r_cnt_2 <= '0;
    end else if (i_ena) begin
      if (i_clr_counts) begin
        r_cnt_1 <= '0;
        r_cnt_2 <= '0;
      end else begin
        if (w_take_1 && (r_cnt_1 != '1)) r_cnt_1 <= r_cnt_1 + CNT_W'(1);
        if (w_take_2 && (r_cnt_2 != '1)) r_cnt_2 <= r_cnt_2 + CNT_W'(1);
      end
    end
  end

  // Gate with enable so a strobe already registered cannot be seen while frozen.
  assign o_coin_1      = r_coin_1 & i_ena;
  assign o_coin_2      = r_coin_2 & i_ena;
  assign o_reject_gate = r_reject;
  assign o_jam         = r_jam;
  assign o_count_1     = r_cnt_1;
  assign o_count_2     = r_cnt_2;

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: each coin transaction predicts its strobe, counts
// and reject/jam windows from the timing rules; a monitor compares every cycle.
module tb_coin_acceptor;
  import coin_pkg::*;

  localparam int D    = 4;
  localparam int J    = 32;
  localparam int CW   = 4;
  localparam int MAXC = 20000;
  localparam int SAT  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          s1;
  logic          s2;
  logic          acc;
  logic          clr;
  logic          coin_1;
  logic          coin_2;
  logic          rej;
  logic          jam;
  logic [CW-1:0] cnt_1;
  logic [CW-1:0] cnt_2;

  coin_acceptor #(
    .DEBOUNCE_CYCLES (D),
    .JAM_CYCLES      (J),
    .CNT_W           (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_ena         (ena),
    .i_sense_1     (s1),
    .i_sense_2     (s2),
    .i_accept_en   (acc),
    .i_clr_counts  (clr),
    .o_coin_1      (coin_1),
    .o_coin_2      (coin_2),
    .o_reject_gate (rej),
    .o_jam         (jam),
    .o_count_1     (cnt_1),
    .o_count_2     (cnt_2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic          c1;
    logic          c2;
    logic [CW-1:0] n1;
    logic [CW-1:0] n2;
  } exp_t;

  exp_t sb[$];
  bit   exp_rej[MAXC];
  bit   exp_jam[MAXC];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   m1     = 0;
  int   m2     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                                 name, cyc, act, req);
    end
  endtask

  task automatic mark(input int a, input int b, input bit is_jam);
    for (int c = a; c <= b && c < MAXC; c++) begin
      exp_rej[c] = 1'b1;
      if (is_jam) exp_jam[c] = 1'b1;
    end
  endtask

  // One physical coin: pattern p high for h cycles then low for l cycles. Enable is
  // dropped for f cycles early in the high phase; c pulses clr_counts at the decision.
  // Sensor rises before edge n; decision (strobe) edge is n+2+D, release edge n+he+1+D.
  task automatic do_coin(input logic [1:0] p, input int h, input bit a, input int l,
                         input int f, input bit c);
    int   k;
    int   n;
    int   he;
    int   t;
    int   e;
    bit   valid;
    exp_t x;
    k     = cyc;
    n     = k + 1;
    he    = h - f;
    t     = n + 2 + D + f;
    e     = n + he + D + f;
    valid = a && (p == COIN_1 || p == COIN_2);
    if (c) begin
      m1 = 0;
      m2 = 0;
    end
    if (he > D) begin
      if (valid) begin
        if (!c && p == COIN_1 && m1 < SAT) m1++;
        if (!c && p == COIN_2 && m2 < SAT) m2++;
        x.cyc = t;
        x.c1  = (p == COIN_1);
        x.c2  = (p == COIN_2);
        x.n1  = CW'(m1);
        x.n2  = CW'(m2);
        sb.push_back(x);
      end else begin
        mark(t, e, 1'b0);
      end
      if (he >= J + D + 1) mark(t + J, e, 1'b1);
    end
    for (int i = 0; i < h + l; i++) begin
      {s1, s2} = (i < h) ? p : COIN_NONE;
      if (i == 0) acc = a;
      // Flip accept_en after the decision; the coin in flight must not notice.
      if (i == D + 3 + f && he > D) acc = ~a;
      ena = !(f > 0 && i >= 2 && i < 2 + f);
      clr = c && (i == D + 2 + f);
      @(negedge clk);
    end
  endtask

  // Monitor: sampled 2 ns after the falling edge, clear of both clock edges.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("strobe_cycle_missed", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (coin_1 === 1'b1 || coin_2 === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", {coin_1, coin_2}, 0);
        end else begin
          e = sb.pop_front();
          check("strobe_cycle", cyc, e.cyc);
          check("strobe_id", {coin_1, coin_2}, {e.c1, e.c2});
          check("count_1", cnt_1, e.n1);
          check("count_2", cnt_2, e.n2);
        end
      end
      if (cyc < MAXC) begin
        check("reject_gate", rej, exp_rej[cyc]);
        check("jam", jam, exp_jam[cyc]);
      end
    end
  end

  initial begin
    #(MAXC * 10 - 100);
    $display("FAIL watchdog: run did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] p;
    int         h;
    int         cat;
    rst_n = 1'b0;
    ena   = 1'b1;
    s1    = 1'b0;
    s2    = 1'b0;
    acc   = 1'b1;
    clr   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {coin_1, coin_2, rej, jam, cnt_1, cnt_2}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_coin(COIN_1, 10, 1'b1, 8, 0, 1'b0);     // plain 1-rupee coin
    do_coin(COIN_2, 2, 1'b1, 8, 0, 1'b0);      // glitch
    do_coin(COIN_BOTH, 10, 1'b1, 8, 0, 1'b0);  // ambiguous -> reject
    do_coin(COIN_2, 10, 1'b0, 8, 0, 1'b0);     // inhibited -> reject
    do_coin(COIN_2, 10, 1'b1, 8, 0, 1'b0);
    do_coin(COIN_1, 60, 1'b1, 8, 0, 1'b0);     // jam after acceptance
    do_coin(COIN_1, D, 1'b1, 8, 0, 1'b0);      // longest glitch
    do_coin(COIN_2, D + 1, 1'b1, 8, 0, 1'b0);  // shortest accepted coin
    do_coin(COIN_1, J + D, 1'b1, 8, 0, 1'b0);  // just below jam
    do_coin(COIN_2, J + D + 1, 1'b0, 8, 0, 1'b0);  // just at jam, from reject
    do_coin(COIN_1, 15, 1'b1, 8, 5, 1'b0);     // freeze mid-debounce

    for (int i = 0; i < 17; i++) do_coin(COIN_1, 6, 1'b1, D + 2, 0, 1'b0);
    do_coin(COIN_1, 8, 1'b1, 8, 0, 1'b1);      // clear wins over increment

    // Reset in the middle of debounce; the coin is still present afterwards.
    s1  = 1'b1;
    acc = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    m1    = 0;
    m2    = 0;
    repeat (2) @(negedge clk);
    #2;
    check("mid_reset_outputs", {coin_1, coin_2, rej, jam, cnt_1, cnt_2}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_coin(COIN_1, 10, 1'b1, 8, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      cat = $urandom_range(0, 9);
      if (cat < 2)       h = $urandom_range(1, D);
      else if (cat == 8) h = $urandom_range(J + D - 1, J + D + 6);
      else if (cat == 9) h = $urandom_range(D + 10, J);
      else               h = $urandom_range(D + 1, D + 12);
      cat = $urandom_range(0, 5);
      p   = (cat < 3) ? COIN_1 : (cat < 5) ? COIN_2 : COIN_BOTH;
      do_coin(p, h, ($urandom_range(0, 4) != 0), D + 3 + $urandom_range(0, 5), 0,
              ($urandom_range(0, 9) == 0));
    end

    repeat (12) @(negedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    check("final_count_1", cnt_1, m1);
    check("final_count_2", cnt_2, m2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
